// File: rtl/raster_scheduler.sv
// raster_scheduler
//   Frame-level sequencer for the rasterizer. Buffers triangle descriptors in
//   a small FIFO, clears the back framebuffer and z-buffer at frame start,
//   launches the rasterizer once per queued triangle, and flips the display
//   buffer when the frame is complete. Owns the framebuffer / z-buffer write
//   ports and muxes them between the clear engine and the rasterizer.
//
//   Optional feature: define RASTER_SCHED_STATS_EN to build the per-frame
//   triangle and cycle counters; otherwise stat_tris/stat_cycles are tied to 0.
//
// Ports
//   clk, rst                  clock, synchronous active-low reset
//   frame_start, frame_end    frame control pulses
//   bg_color                  clear color, sampled when frame_start is accepted
//   tri_valid/tri_ready       descriptor push handshake, tri_desc payload
//   rast_desc, rast_start     descriptor + launch pulse to the rasterizer
//   rast_done                 rasterizer completion pulse
//   rast_fb_*/rast_zb_*       rasterizer memory requests (passed through in WAIT)
//   fb_we/fb_addr/fb_din      back-framebuffer write port
//   zb_we/zb_addr/zb_din      z-buffer write/read-address port
//   display_buf               front buffer index
//   busy, frame_done          status
//   stat_tris, stat_cycles    statistics
module raster_scheduler #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NPIX   = 76800,
  parameter logic [7:0]  ZCLEAR = 8'hFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic         frame_end,
  input  logic [7:0]   bg_color,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [235:0] tri_desc,
  output logic [235:0] rast_desc,
  output logic         rast_start,
  input  logic         rast_done,
  input  logic         rast_fb_we,
  input  logic [16:0]  rast_fb_addr,
  input  logic [7:0]   rast_fb_din,
  input  logic         rast_zb_we,
  input  logic [16:0]  rast_zb_addr,
  input  logic [7:0]   rast_zb_din,
  output logic         fb_we,
  output logic [16:0]  fb_addr,
  output logic [7:0]   fb_din,
  output logic         zb_we,
  output logic [16:0]  zb_addr,
  output logic [7:0]   zb_din,
  output logic         display_buf,
  output logic         busy,
  output logic         frame_done,
  output logic [15:0]  stat_tris,
  output logic [31:0]  stat_cycles
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [16:0] LAST_PIX = 17'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_FLIP
  } state_t;

  state_t        r_state, w_next;

  logic [235:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_push, w_pop, w_accept;

  logic [16:0]   r_clr_cnt;
  logic [7:0]    r_bg;
  logic          r_end_seen;
  logic          r_disp;
  logic          r_frame_done;
  logic [235:0]  r_rast_desc;

  // Last driven address/data, held on the ports while neither source owns them
  logic [16:0]   r_fb_addr, r_zb_addr;
  logic [7:0]    r_fb_din, r_zb_din;

  logic          w_fb_we, w_zb_we;
  logic [16:0]   w_fb_addr, w_zb_addr;
  logic [7:0]    w_fb_din, w_zb_din;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = tri_valid & ~w_full;
  assign w_pop    = (r_state == S_FETCH) & ~w_empty;
  assign w_accept = (r_state == S_IDLE) & frame_start;

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (frame_start) w_next = S_CLEAR;
      S_CLEAR:  if (r_clr_cnt == LAST_PIX) w_next = S_FETCH;
      S_FETCH: begin
        if (!w_empty)        w_next = S_LAUNCH;
        else if (r_end_seen) w_next = S_FLIP;
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (rast_done) w_next = S_FETCH;
      S_FLIP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Memory port mux: combinational so rasterizer accesses see no extra latency
  always_comb begin
    w_fb_we   = 1'b0;
    w_zb_we   = 1'b0;
    w_fb_addr = r_fb_addr;
    w_fb_din  = r_fb_din;
    w_zb_addr = r_zb_addr;
    w_zb_din  = r_zb_din;
    unique case (r_state)
      S_CLEAR: begin
        w_fb_we   = 1'b1;
        w_zb_we   = 1'b1;
        w_fb_addr = r_clr_cnt;
        w_zb_addr = r_clr_cnt;
        w_fb_din  = r_bg;
        w_zb_din  = ZCLEAR;
      end
      S_WAIT: begin
        w_fb_we   = rast_fb_we;
        w_fb_addr = rast_fb_addr;
        w_fb_din  = rast_fb_din;
        w_zb_we   = rast_zb_we;
        w_zb_addr = rast_zb_addr;
        w_zb_din  = rast_zb_din;
      end
      default: ;
    endcase
  end

  // Descriptor storage; pointers carry the reset so no reset is needed here
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tri_desc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_clr_cnt    <= '0;
      r_bg         <= '0;
      r_end_seen   <= 1'b0;
      r_disp       <= 1'b0;
      r_frame_done <= 1'b0;
      r_rast_desc  <= '0;
      r_fb_addr    <= '0;
      r_fb_din     <= '0;
      r_zb_addr    <= '0;
      r_zb_din     <= '0;
    end else begin
      r_state <= w_next;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_rast_desc <= r_mem[r_rd_ptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase

      if (w_accept) begin
        r_bg      <= bg_color;
        r_clr_cnt <= '0;
      end else if (r_state == S_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end

      // frame_end arriving together with an accepted frame_start still counts
      if (r_state == S_FLIP)
        r_end_seen <= 1'b0;
      else if (frame_end && (r_state != S_IDLE || frame_start))
        r_end_seen <= 1'b1;

      if (r_state == S_FLIP) r_disp <= ~r_disp;
      r_frame_done <= (r_state == S_FLIP);

      r_fb_addr <= w_fb_addr;
      r_fb_din  <= w_fb_din;
      r_zb_addr <= w_zb_addr;
      r_zb_din  <= w_zb_din;
    end
  end

`ifdef RASTER_SCHED_STATS_EN
  logic [15:0] r_stat_tris;
  logic [31:0] r_stat_cycles;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_tris   <= '0;
      r_stat_cycles <= '0;
    end else begin
      if (w_accept)
        r_stat_tris <= '0;
      else if (r_state == S_LAUNCH && r_stat_tris != '1)
        r_stat_tris <= r_stat_tris + 1'b1;

      // Acceptance cycle counts as the first; counting stops after FLIP
      if (w_accept)
        r_stat_cycles <= 32'd1;
      else if (r_state != S_IDLE)
        r_stat_cycles <= r_stat_cycles + 1'b1;
    end
  end

  assign stat_tris   = r_stat_tris;
  assign stat_cycles = r_stat_cycles;
`else
  assign stat_tris   = '0;
  assign stat_cycles = '0;
`endif

  assign tri_ready   = ~w_full;
  assign rast_desc   = r_rast_desc;
  assign rast_start  = (r_state == S_LAUNCH);
  assign fb_we       = w_fb_we;
  assign fb_addr     = w_fb_addr;
  assign fb_din      = w_fb_din;
  assign zb_we       = w_zb_we;
  assign zb_addr     = w_zb_addr;
  assign zb_din      = w_zb_din;
  assign display_buf = r_disp;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_frame_done;

endmodule
